fp13_multiplier: RTL and testbench

- Registered multiplier for a custom 13-bit floating-point format.
- Format: [12] sign, [11:8] exponent (bias 7), [7:0] fraction with hidden leading 1.
- Produces the product of two operands one clock after they are presented.
- Used as the compute core under the GP02 Ej1 top level.

---
 rtl/fp13_pkg.sv | 16 +
 rtl/fp13_mul_comb.sv | 72 +++++++
 rtl/fp13_multiplier.sv | 61 ++++++
 tb/tb_fp13_multiplier.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fp13_pkg.sv
// Shared constants and operand layout for the 13-bit floating-point multiplier.
package fp13_pkg;

    localparam int unsigned EXP_W      = 4;
    localparam int unsigned MAN_W      = 8;
    localparam int unsigned BIAS       = 7;
    localparam int unsigned FP_W       = 13;
    localparam logic [11:0] FP_MAX_MAG = 12'hFFF;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp13_t;

endpackage

// File: rtl/fp13_mul_comb.sv
// Combinational sign/exponent/mantissa/normalise/saturate logic for the fp13 product.
// Optional flag outputs are present when FP13_MUL_FLAGS_EN is defined.
module fp13_mul_comb
    import fp13_pkg::*;
#(
    parameter int unsigned EXP_W = fp13_pkg::EXP_W,
    parameter int unsigned MAN_W = fp13_pkg::MAN_W,
    parameter int unsigned BIAS  = fp13_pkg::BIAS
) (
    input  logic [EXP_W+MAN_W:0] op_a,
    input  logic [EXP_W+MAN_W:0] op_b,
`ifdef FP13_MUL_FLAGS_EN
    output logic                 overflow,
    output logic                 underflow,
`endif
    output logic [EXP_W+MAN_W:0] product
);

    localparam int unsigned EW   = EXP_W + 3;
    localparam int unsigned MW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * MW;
    localparam int unsigned MSB  = EXP_W + MAN_W;

    fp13_t a;
    fp13_t b;

    logic [MW-1:0]        mant_a;
    logic [MW-1:0]        mant_b;
    logic [PW-1:0]        prod;
    logic                 norm;
    logic [MAN_W-1:0]     frac;
    logic                 sign;
    logic signed [EW-1:0] exp_sum;
    logic                 zero_op;
    logic                 unf;
    logic                 ovf;

    assign a = op_a;
    assign b = op_b;

    assign sign   = a.sign ^ b.sign;
    assign mant_a = {1'b1, a.frac};
    assign mant_b = {1'b1, b.frac};
    assign prod   = mant_a * mant_b;

    // Product of two [1,2) mantissas lies in [1,4); the top bit selects the shift.
    assign norm = prod[PW-1];
    assign frac = norm ? MAN_W'(prod >> MW) : MAN_W'(prod >> MAN_W);

    assign exp_sum = $signed(EW'(a.exp)) + $signed(EW'(b.exp))
                   - $signed(EW'(BIAS)) + $signed(EW'(norm));

    assign zero_op = (a.exp == '0) || (b.exp == '0);
    assign unf     = !zero_op && (exp_sum < $signed(EW'(1)));
    assign ovf     = !zero_op && (exp_sum > $signed(EW'((1 << EXP_W) - 1)));

    always_comb begin
        product = '0;
        if (ovf) begin
            product      = '1;
            product[MSB] = sign;
        end else if (!zero_op && !unf) begin
            product = {sign, exp_sum[EXP_W-1:0], frac};
        end
    end

`ifdef FP13_MUL_FLAGS_EN
    assign overflow  = ovf;
    assign underflow = unf;
`endif

endmodule

// File: rtl/fp13_multiplier.sv
// Registered 13-bit floating-point multiplier, one cycle of latency.
// Define FP13_MUL_FLAGS_EN to add registered o_overflow / o_underflow outputs.
module fp13_multiplier
    import fp13_pkg::*;
#(
    parameter int unsigned EXP_W = fp13_pkg::EXP_W,
    parameter int unsigned MAN_W = fp13_pkg::MAN_W,
    parameter int unsigned BIAS  = fp13_pkg::BIAS
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic [EXP_W+MAN_W:0] i_flotante_1,
    input  logic [EXP_W+MAN_W:0] i_flotante_2,
`ifdef FP13_MUL_FLAGS_EN
    output logic                 o_overflow,
    output logic                 o_underflow,
`endif
    output logic [EXP_W+MAN_W:0] o_mutiplicado
);

    logic [EXP_W+MAN_W:0] product;
`ifdef FP13_MUL_FLAGS_EN
    logic overflow;
    logic underflow;
`endif

    fp13_mul_comb #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .BIAS  (BIAS)
    ) u_comb (
        .op_a      (i_flotante_1),
        .op_b      (i_flotante_2),
`ifdef FP13_MUL_FLAGS_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .product   (product)
    );

    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_mutiplicado <= '0;
        end else begin
            o_mutiplicado <= product;
        end
    end

`ifdef FP13_MUL_FLAGS_EN
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= overflow;
            o_underflow <= underflow;
        end
    end
`endif

endmodule

// File: tb/tb_fp13_multiplier.sv
// Self-checking bench for fp13_multiplier: directed, boundary, random and reset scenarios
// against a real-arithmetic reference model.
module tb_fp13_multiplier;

    logic        clock;
    logic        i_reset;
    logic [12:0] i_flotante_1;
    logic [12:0] i_flotante_2;
    logic [12:0] o_mutiplicado;
`ifdef FP13_MUL_FLAGS_EN
    logic        o_overflow;
    logic        o_underflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fp13_multiplier dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_flotante_1  (i_flotante_1),
        .i_flotante_2  (i_flotante_2),
`ifdef FP13_MUL_FLAGS_EN
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow),
`endif
        .o_mutiplicado (o_mutiplicado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: value-level multiply of the two significands, normalised by halving.
    function automatic logic [12:0] model(input logic [12:0] a, input logic [12:0] b,
                                          output logic ovf, output logic unf);
        int  ea, eb, k, e, fr;
        real val;
        ea  = int'(a[11:8]);
        eb  = int'(b[11:8]);
        ovf = 1'b0;
        unf = 1'b0;
        if (ea == 0 || eb == 0) return 13'd0;
        val = ((256.0 + real'(a[7:0])) / 256.0) * ((256.0 + real'(b[7:0])) / 256.0);
        k = 0;
        while (val >= 2.0) begin
            val = val / 2.0;
            k++;
        end
        e  = ea + eb - 7 + k;
        fr = $rtoi((val - 1.0) * 256.0);
        if (e < 1) begin
            unf = 1'b1;
            return 13'd0;
        end
        if (e > 15) begin
            ovf = 1'b1;
            return {a[12] ^ b[12], 12'hFFF};
        end
        return {a[12] ^ b[12], 4'(e), 8'(fr)};
    endfunction

    task automatic drive(input logic [12:0] a, input logic [12:0] b);
        i_flotante_1 = a;
        i_flotante_2 = b;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        drive(13'b0_1100_00011101, 13'b0_0011_11001101);
        n_checks++;
        if (o_mutiplicado !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", o_mutiplicado, 13'd0);
        end
`ifdef FP13_MUL_FLAGS_EN
        n_checks++;
        if ({o_overflow, o_underflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00", {o_overflow, o_underflow});
        end
`endif
        i_reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [12:0] va[6];
        logic [12:0] vb[6];
        logic [12:0] ve[6];
        va[0] = 13'b1_0101_11000110; vb[0] = 13'b0_1100_00011101; ve[0] = 13'b1_1010_11111001;
        va[1] = 13'b0_0011_11001101; vb[1] = 13'b1_1011_00101011; ve[1] = 13'b1_1000_00001101;
        va[2] = 13'b1_1011_00101011; vb[2] = 13'b0_0011_11001101; ve[2] = 13'b1_1000_00001101;
        va[3] = 13'b0_1100_00011101; vb[3] = 13'b0_0011_11001101; ve[3] = 13'b0_1001_00000000;
        va[4] = 13'b1_0101_11000110; vb[4] = 13'b1_1011_00101011; ve[4] = 13'b0_1010_00001001;
        va[5] = 13'b0_0111_00000000; vb[5] = 13'b1_0111_10000000; ve[5] = 13'b1_0111_10000000;
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vb[i]);
            n_checks++;
            if (o_mutiplicado !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got %b expected %b", i, o_mutiplicado, ve[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [12:0] va[5];
        logic [12:0] vb[5];
        logic [12:0] ve[5];
        logic [1:0]  vf[5];
        va[0] = 13'b0_1111_11111111; vb[0] = 13'b0_1111_11111111; ve[0] = 13'b0_1111_11111111; vf[0] = 2'b10;
        va[1] = 13'b0_0001_00000000; vb[1] = 13'b0_0001_00000000; ve[1] = 13'd0;              vf[1] = 2'b01;
        va[2] = 13'b1_0000_10101010; vb[2] = 13'b0_1100_00011101; ve[2] = 13'd0;              vf[2] = 2'b00;
        va[3] = 13'b0_1111_11111111; vb[3] = 13'b1_0000_11111111; ve[3] = 13'd0;              vf[3] = 2'b00;
        va[4] = 13'b1_1111_00000000; vb[4] = 13'b0_1001_00000000; ve[4] = 13'b1_1111_11111111; vf[4] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i]);
            n_checks++;
            if (o_mutiplicado !== ve[i]) begin
                n_fail++;
                $display("FAIL boundary_%0d: got %b expected %b", i, o_mutiplicado, ve[i]);
            end
`ifdef FP13_MUL_FLAGS_EN
            n_checks++;
            if ({o_overflow, o_underflow} !== vf[i]) begin
                n_fail++;
                $display("FAIL boundary_flags_%0d: got %b expected %b", i,
                         {o_overflow, o_underflow}, vf[i]);
            end
`else
            if (vf[i] === 2'bxx) $display("unreachable");
`endif
        end
    endtask

    // Operands change every cycle; swapped pairs must give the identical result.
    task automatic test_back_to_back();
        logic [12:0] a, b, exp_v;
        logic        ovf, unf;
        for (int i = 0; i < 300; i++) begin
            a = 13'($urandom);
            b = 13'($urandom);
            exp_v = model(a, b, ovf, unf);
            drive((i % 2 == 0) ? a : b, (i % 2 == 0) ? b : a);
            n_checks++;
            if (o_mutiplicado !== exp_v) begin
                n_fail++;
                $display("FAIL random_%0d: a=%b b=%b got %b expected %b", i, a, b,
                         o_mutiplicado, exp_v);
            end
`ifdef FP13_MUL_FLAGS_EN
            n_checks++;
            if ({o_overflow, o_underflow} !== {ovf, unf}) begin
                n_fail++;
                $display("FAIL random_flags_%0d: got %b expected %b", i,
                         {o_overflow, o_underflow}, {ovf, unf});
            end
`endif
        end
    endtask

    task automatic test_reset_midstream();
        logic [12:0] a, b, exp_v;
        logic        ovf, unf;
        drive(13'b0_1100_00011101, 13'b0_0011_11001101);
        i_reset = 1'b1;
        drive(13'b1_0101_11000110, 13'b0_1100_00011101);
        n_checks++;
        if (o_mutiplicado !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_midstream: got %b expected %b", o_mutiplicado, 13'd0);
        end
        i_reset = 1'b0;
        a = 13'b0_1000_01000000;
        b = 13'b1_0111_11000000;
        exp_v = model(a, b, ovf, unf);
        drive(a, b);
        n_checks++;
        if (o_mutiplicado !== exp_v) begin
            n_fail++;
            $display("FAIL after_release: got %b expected %b", o_mutiplicado, exp_v);
        end
    endtask

    initial begin
        i_reset      = 1'b1;
        i_flotante_1 = '0;
        i_flotante_2 = '0;
        test_reset();
        test_directed();
        test_boundary();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
